// File: rtl/reg_f_ctx_if.sv
// reg_f_ctx_if: port bundle for the context-stacked register file.
// master drives addresses, write data and stack commands; slave is the register file.
interface reg_f_ctx_if #(
    parameter int WIDTH       = 8,
    parameter int REG_COUNT   = 11,
    parameter int STACK_DEPTH = 8
);
    localparam int AW  = $clog2(REG_COUNT);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    logic [AW-1:0]    rf_addr_r1;
    logic [WIDTH-1:0] rf_data_out1;
    logic [AW-1:0]    rf_addr_r2;
    logic [WIDTH-1:0] rf_data_out2;
    logic [AW-1:0]    rf_addr_wr;
    logic             rf_data_we;
    logic [WIDTH-1:0] rf_data_in;
    logic             rf_stack_push;
    logic             rf_stack_pop;
    logic [SPW-1:0]   rf_stack_sp;
    logic             rf_stack_full;
    logic             rf_stack_empty;
    logic             rf_stack_err;
    logic             rf_acc_zero;
    modport master (
        output rf_addr_r1, rf_addr_r2, rf_addr_wr, rf_data_we, rf_data_in, rf_stack_push, rf_stack_pop,
        input  rf_data_out1, rf_data_out2, rf_stack_sp, rf_stack_full, rf_stack_empty, rf_stack_err, rf_acc_zero
    );
    modport slave (
        input  rf_addr_r1, rf_addr_r2, rf_addr_wr, rf_data_we, rf_data_in, rf_stack_push, rf_stack_pop,
        output rf_data_out1, rf_data_out2, rf_stack_sp, rf_stack_full, rf_stack_empty, rf_stack_err, rf_acc_zero
    );
endinterface

// File: rtl/reg_f_ctx.sv
// reg_f_ctx: register file with constant R0/R1, ACC at address 2 and a LIFO of saved contexts.
// CALL saves and clears ACC..top, RET restores it; bad stack commands set a sticky error.
module reg_f_ctx #(
    parameter int WIDTH       = 8,
    parameter int REG_COUNT   = 11,
    parameter int STACK_DEPTH = 8
) (
    input logic        clk,
    input logic        rst_n,
    reg_f_ctx_if.slave bus
);
    localparam int AW  = $clog2(REG_COUNT);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int NR  = REG_COUNT - 2;
    logic [NR-1:0][WIDTH-1:0] regs_q, regs_d, top;
    logic [NR-1:0][WIDTH-1:0] frame_q [STACK_DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic err_q, err_d;
    logic full, empty, push_only, pop_only, do_push, do_pop, we_ok;
    assign full      = sp_q == SPW'(STACK_DEPTH);
    assign empty     = sp_q == '0;
    assign push_only = bus.rf_stack_push & ~bus.rf_stack_pop;
    assign pop_only  = bus.rf_stack_pop & ~bus.rf_stack_push;
    assign do_push   = push_only & ~full;
    assign do_pop    = pop_only & ~empty;
    assign we_ok     = bus.rf_data_we & ~bus.rf_stack_push & ~bus.rf_stack_pop;
    always_comb begin
        bus.rf_data_out1 = bus.rf_addr_r1 == AW'(1) ? '1 : '0;
        bus.rf_data_out2 = bus.rf_addr_r2 == AW'(1) ? '1 : '0;
        for (int i = 0; i < NR; i++) begin
            if (bus.rf_addr_r1 == AW'(i + 2)) bus.rf_data_out1 = regs_q[i];
            if (bus.rf_addr_r2 == AW'(i + 2)) bus.rf_data_out2 = regs_q[i];
        end
    end
    always_comb begin
        top = '0;
        for (int j = 0; j < STACK_DEPTH; j++)
            if (sp_q == SPW'(j + 1)) top = frame_q[j];
        regs_d = regs_q;
        for (int i = 0; i < NR; i++)
            if (we_ok && bus.rf_addr_wr == AW'(i + 2)) regs_d[i] = bus.rf_data_in;
        regs_d = do_push ? '0 : do_pop ? top : regs_d;
        sp_d   = do_push ? sp_q + 1'b1 : do_pop ? sp_q - 1'b1 : sp_q;
        err_d  = err_q | (bus.rf_stack_push & bus.rf_stack_pop) | (push_only & full) | (pop_only & empty);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            sp_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            sp_q   <= sp_d;
            err_q  <= err_d;
        end
    end
    // Frame storage is deliberately left unreset; sp guards every read.
    always_ff @(posedge clk)
        for (int j = 0; j < STACK_DEPTH; j++)
            if (do_push && sp_q == SPW'(j)) frame_q[j] <= regs_q;
    assign bus.rf_stack_sp    = sp_q;
    assign bus.rf_stack_full  = full;
    assign bus.rf_stack_empty = empty;
    assign bus.rf_stack_err   = err_q;
    // Look-ahead: the zero flag reflects the ACC value that the next edge will load.
    assign bus.rf_acc_zero    = regs_d[0] == '0;
endmodule

// File: tb/tb_reg_f_ctx.sv
// tb_reg_f_ctx: directed checks of reads, writes, CALL/RET stacking, errors and the ACC zero look-ahead.
module tb_reg_f_ctx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    reg_f_ctx_if #(.WIDTH(8), .REG_COUNT(11), .STACK_DEPTH(8)) bus ();
    reg_f_ctx #(.WIDTH(8), .REG_COUNT(11), .STACK_DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.rf_addr_wr = a;
        bus.rf_data_in = d;
        bus.rf_data_we = 1'b1;
        cyc();
        bus.rf_data_we = 1'b0;
    endtask
    task automatic stk(input logic p, input logic q);
        bus.rf_stack_push = p;
        bus.rf_stack_pop  = q;
        cyc();
        bus.rf_stack_push = 1'b0;
        bus.rf_stack_pop  = 1'b0;
    endtask
    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        bus.rf_addr_r1 = a1;
        bus.rf_addr_r2 = a2;
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        bus.rf_addr_r1 = 4'd2;
        bus.rf_addr_r2 = 4'd3;
        bus.rf_addr_wr = '0;
        bus.rf_data_we = 1'b0;
        bus.rf_data_in = '0;
        bus.rf_stack_push = 1'b0;
        bus.rf_stack_pop  = 1'b0;
        #2;
        chk("rst_sp", bus.rf_stack_sp, 0);
        chk("rst_empty", bus.rf_stack_empty, 1);
        chk("rst_full", bus.rf_stack_full, 0);
        chk("rst_err", bus.rf_stack_err, 0);
        chk("rst_acc", bus.rf_data_out1, 0);
        rst_n = 1'b1;
        cyc();
        wr(4'd2, 8'h5A);
        wr(4'd3, 8'h33);
        rd(4'd2, 4'd3);
        chk("t1_acc", bus.rf_data_out1, 8'h5A);
        chk("t1_r3", bus.rf_data_out2, 8'h33);
        wr(4'd0, 8'hAA);
        wr(4'd1, 8'h11);
        wr(4'd15, 8'h77);
        rd(4'd0, 4'd1);
        chk("t1_r0", bus.rf_data_out1, 8'h00);
        chk("t1_r1", bus.rf_data_out2, 8'hFF);
        rd(4'd15, 4'd11);
        chk("t1_oob15", bus.rf_data_out1, 8'h00);
        chk("t1_oob11", bus.rf_data_out2, 8'h00);
        rd(4'd2, 4'd3);
        chk("t1_acc_kept", bus.rf_data_out1, 8'h5A);
        chk("t1_zero_nz", bus.rf_acc_zero, 0);
        bus.rf_stack_push = 1'b1;
        #1;
        chk("t2_zero_push", bus.rf_acc_zero, 1);
        cyc();
        bus.rf_stack_push = 1'b0;
        #1;
        chk("t2_sp1", bus.rf_stack_sp, 1);
        chk("t2_acc_clr", bus.rf_data_out1, 0);
        chk("t2_r3_clr", bus.rf_data_out2, 0);
        wr(4'd2, 8'h07);
        chk("t2_acc7", bus.rf_data_out1, 8'h07);
        bus.rf_stack_pop = 1'b1;
        #1;
        chk("t2_zero_pop", bus.rf_acc_zero, 0);
        cyc();
        bus.rf_stack_pop = 1'b0;
        #1;
        chk("t2_acc_rest", bus.rf_data_out1, 8'h5A);
        chk("t2_r3_rest", bus.rf_data_out2, 8'h33);
        chk("t2_sp0", bus.rf_stack_sp, 0);
        for (int i = 0; i < 8; i++) begin
            wr(4'd2, 8'h10 + 8'(i));
            wr(4'd3, 8'h80 + 8'(i));
            stk(1'b1, 1'b0);
        end
        chk("t3_full", bus.rf_stack_full, 1);
        chk("t3_sp8", bus.rf_stack_sp, 8);
        chk("t3_err0", bus.rf_stack_err, 0);
        wr(4'd2, 8'hEE);
        stk(1'b1, 1'b0);
        chk("t3_ovf_err", bus.rf_stack_err, 1);
        chk("t3_ovf_sp", bus.rf_stack_sp, 8);
        chk("t3_ovf_acc", bus.rf_data_out1, 8'hEE);
        for (int i = 7; i >= 0; i--) begin
            stk(1'b0, 1'b1);
            chk($sformatf("t3_pop_acc%0d", i), bus.rf_data_out1, 8'h10 + 8'(i));
            chk($sformatf("t3_pop_r3_%0d", i), bus.rf_data_out2, 8'h80 + 8'(i));
        end
        chk("t3_empty", bus.rf_stack_empty, 1);
        do_reset();
        wr(4'd2, 8'h42);
        stk(1'b0, 1'b1);
        chk("t4_unf_err", bus.rf_stack_err, 1);
        chk("t4_unf_acc", bus.rf_data_out1, 8'h42);
        chk("t4_unf_sp", bus.rf_stack_sp, 0);
        do_reset();
        wr(4'd2, 8'h42);
        stk(1'b1, 1'b1);
        chk("t4_both_err", bus.rf_stack_err, 1);
        chk("t4_both_sp", bus.rf_stack_sp, 0);
        chk("t4_both_acc", bus.rf_data_out1, 8'h42);
        do_reset();
        wr(4'd2, 8'h42);
        bus.rf_addr_wr = 4'd2;
        bus.rf_data_in = 8'h99;
        bus.rf_data_we = 1'b1;
        stk(1'b1, 1'b0);
        bus.rf_data_we = 1'b0;
        chk("t4_wepush_sp", bus.rf_stack_sp, 1);
        chk("t4_wepush_acc", bus.rf_data_out1, 0);
        chk("t4_wepush_err", bus.rf_stack_err, 0);
        stk(1'b0, 1'b1);
        chk("t4_wepush_rest", bus.rf_data_out1, 8'h42);
        wr(4'd2, 8'h01);
        bus.rf_addr_wr = 4'd2;
        bus.rf_data_in = 8'h00;
        bus.rf_data_we = 1'b1;
        #1;
        chk("t5_zero_ld0", bus.rf_acc_zero, 1);
        cyc();
        bus.rf_data_in = 8'h10;
        #1;
        chk("t5_zero_ld10", bus.rf_acc_zero, 0);
        cyc();
        bus.rf_data_we = 1'b0;
        #1;
        chk("t5_acc10", bus.rf_data_out1, 8'h10);
        chk("t5_zero_after", bus.rf_acc_zero, 0);
        for (int i = 0; i < 3; i++) begin
            wr(4'd3, 8'h20 + 8'(i));
            stk(1'b1, 1'b0);
        end
        wr(4'd2, 8'h55);
        wr(4'd3, 8'h66);
        stk(1'b1, 1'b1);
        chk("t6_pre_sp", bus.rf_stack_sp, 3);
        chk("t6_pre_err", bus.rf_stack_err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sp", bus.rf_stack_sp, 0);
        chk("t6_rst_err", bus.rf_stack_err, 0);
        chk("t6_rst_acc", bus.rf_data_out1, 0);
        chk("t6_rst_r3", bus.rf_data_out2, 0);
        chk("t6_rst_empty", bus.rf_stack_empty, 1);
        rst_n = 1'b1;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
